// File: rtl/t_ff_pkg.sv
// t_ff_pkg: shared types for the toggle flip-flop front end.
// Debounce FSM state encoding, limits and state decode helpers.
package t_ff_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } dbnc_state_t;

   localparam int DEBOUNCE_MIN = 2;

   // A level change is being qualified.
   function automatic logic is_chk(dbnc_state_t s);
      return (s == PRESS_CHK) || (s == RELEASE_CHK);
   endfunction

   // The debounced button is considered pressed.
   function automatic logic is_level(dbnc_state_t s);
      return (s == HELD) || (s == RELEASE_CHK);
   endfunction

endpackage

// File: rtl/t_toggle_debounce_if.sv
// t_toggle_debounce_if: button-in / toggle-out bundle.
// master drives the raw line and enable, slave is the debouncer.
interface t_toggle_debounce_if;

   logic btn_in;
   logic en;
   logic t;
   logic btn_level;
   logic busy;

   modport master (
      output btn_in,
      output en,
      input  t,
      input  btn_level,
      input  busy
   );

   modport slave (
      input  btn_in,
      input  en,
      output t,
      output btn_level,
      output busy
   );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-stage synchroniser for asynchronous inputs.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   // Shift the raw input through two flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/t_toggle_debounce.sv
// t_toggle_debounce: synchronise and debounce a push button.
// Emits one registered t pulse per qualified press.
module t_toggle_debounce
   import t_ff_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic               clk,
   input  logic               reset,
   t_toggle_debounce_if.slave bus
);

   if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_cycles
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   if (CNT_W < $clog2(DEBOUNCE_CYCLES)) begin : g_bad_width
      $error("CNT_W too narrow for DEBOUNCE_CYCLES");
   end

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s2;
   dbnc_state_t      state_q;
   dbnc_state_t      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             press_ok;
   logic             t_q;
   logic             t_d;
   logic             lvl_q;
   logic             lvl_d;
   logic             busy_q;
   logic             busy_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.btn_in),
      .q     (s2)
   );

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         t_q     <= 1'b0;
         lvl_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         lvl_q   <= lvl_d;
         busy_q  <= busy_d;
      end
   end

   // Next state: count consecutive opposite samples,
   // abort on any sample that agrees with the current level.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      press_ok = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s2) begin
               state_d = PRESS_CHK;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_CHK: begin
            if (!s2) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = HELD;
               cnt_d    = '0;
               press_ok = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!s2) begin
               state_d = RELEASE_CHK;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_CHK: begin
            if (s2) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the state being entered; a press
   // qualified with en low is consumed without a pulse.
   always_comb begin
      t_d    = press_ok & bus.en;
      lvl_d  = is_level(state_d);
      busy_d = is_chk(state_d);
   end

   assign bus.t         = t_q;
   assign bus.btn_level = lvl_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_t_toggle_debounce.sv
// tb_t_toggle_debounce: scenario tasks plus randomized run,
// checked against a run-length model of the debounce rules.
module tb_t_toggle_debounce;

   localparam int N = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   t_toggle_debounce_if bus ();

   t_toggle_debounce #(
      .DEBOUNCE_CYCLES (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Model: the FSM sees btn_in two edges late; the level
   // flips after N consecutive samples that disagree with it.
   bit q[$];
   bit m_lvl = 1'b0;
   bit m_t   = 1'b0;
   int m_run = 0;

   always @(posedge clk) begin
      bit smp;
      if (reset) begin
         q     = '{1'b0, 1'b0};
         m_run = 0;
         m_lvl = 1'b0;
         m_t   = 1'b0;
      end else begin
         q.push_back(bus.btn_in);
         smp = q.pop_front();
         m_t = 1'b0;
         if (smp == m_lvl) begin
            m_run = 0;
         end else begin
            m_run++;
            if (m_run == N) begin
               m_lvl = ~m_lvl;
               m_run = 0;
               m_t   = m_lvl & bus.en;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic go_idle();
      bus.btn_in = 1'b0;
      repeat (2 * N + 4) tick();
   endtask

   task automatic test_reset();
      int pulses = 0;
      int at     = -1;
      reset      = 1'b1;
      bus.btn_in = 1'b1;
      bus.en     = 1'b1;
      repeat (2) begin
         tick();
         checks++;
         if ({bus.t, bus.btn_level, bus.busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outs got=%b exp=000",
                     {bus.t, bus.btn_level, bus.busy});
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (bus.t === 1'b1) begin
            pulses++;
            at = i;
         end
         checks++;
         if ({bus.t, bus.btn_level, bus.busy} !==
             {m_t, m_lvl, m_run != 0}) begin
            fails++;
            $display("FAIL reset_model cyc=%0d got=%b exp=%b", i,
                     {bus.t, bus.btn_level, bus.busy},
                     {m_t, m_lvl, m_run != 0});
         end
      end
      checks++;
      if (pulses !== 1 || at !== N + 2) begin
         fails++;
         $display("FAIL reset_pulse got=%0d@%0d exp=1@%0d",
                  pulses, at, N + 2);
      end
   endtask

   task automatic test_clean_press();
      int pulses = 0;
      int at     = -1;
      int fall   = -1;
      go_idle();
      bus.en     = 1'b1;
      bus.btn_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.t === 1'b1) begin
            pulses++;
            at = i;
         end
         checks++;
         if (bus.btn_level !== (i >= N + 2)) begin
            fails++;
            $display("FAIL press_level cyc=%0d got=%b exp=%b",
                     i, bus.btn_level, i >= N + 2);
         end
         checks++;
         if ({bus.t, bus.btn_level, bus.busy} !==
             {m_t, m_lvl, m_run != 0}) begin
            fails++;
            $display("FAIL press_model cyc=%0d got=%b exp=%b", i,
                     {bus.t, bus.btn_level, bus.busy},
                     {m_t, m_lvl, m_run != 0});
         end
      end
      checks++;
      if (pulses !== 1 || at !== N + 2) begin
         fails++;
         $display("FAIL press_pulse got=%0d@%0d exp=1@%0d",
                  pulses, at, N + 2);
      end
      bus.btn_in = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (bus.btn_level === 1'b0 && fall < 0) fall = i;
         checks++;
         if (bus.t !== 1'b0) begin
            fails++;
            $display("FAIL release_t cyc=%0d got=%b exp=0",
                     i, bus.t);
         end
      end
      checks++;
      if (fall !== N + 2) begin
         fails++;
         $display("FAIL release_latency got=%0d exp=%0d",
                  fall, N + 2);
      end
   endtask

   task automatic test_bounce();
      bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int pulses = 0;
      int at     = -1;
      go_idle();
      bus.en = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         bus.btn_in = (i <= 6) ? pat[i-1] : 1'b1;
         tick();
         if (bus.t === 1'b1) begin
            pulses++;
            at = i;
         end
         checks++;
         if ({bus.t, bus.btn_level, bus.busy} !==
             {m_t, m_lvl, m_run != 0}) begin
            fails++;
            $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i,
                     {bus.t, bus.btn_level, bus.busy},
                     {m_t, m_lvl, m_run != 0});
         end
      end
      checks++;
      if (pulses !== 1 || at !== 6 + N + 1) begin
         fails++;
         $display("FAIL bounce_pulse got=%0d@%0d exp=1@%0d",
                  pulses, at, 6 + N + 1);
      end
   endtask

   task automatic test_release_glitch();
      bit busy_seen = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         bus.btn_in = (i <= 2) ? 1'b0 : 1'b1;
         tick();
         if (bus.busy === 1'b1) busy_seen = 1'b1;
         checks++;
         if (bus.btn_level !== 1'b1 || bus.t !== 1'b0) begin
            fails++;
            $display("FAIL glitch_outs cyc=%0d got=%b%b exp=10",
                     i, bus.btn_level, bus.t);
         end
      end
      checks++;
      if (busy_seen !== 1'b1) begin
         fails++;
         $display("FAIL glitch_busy got=%b exp=1", busy_seen);
      end
   endtask

   task automatic test_enable_gating();
      go_idle();
      bus.en     = 1'b0;
      bus.btn_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 10) bus.en = 1'b1;
         tick();
         checks++;
         if (bus.t !== 1'b0) begin
            fails++;
            $display("FAIL gate_t cyc=%0d got=%b exp=0", i, bus.t);
         end
      end
      checks++;
      if (bus.btn_level !== 1'b1) begin
         fails++;
         $display("FAIL gate_level got=%b exp=1", bus.btn_level);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      int at     = -1;
      go_idle();
      bus.en     = 1'b1;
      bus.btn_in = 1'b1;
      repeat (4) tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.btn_level !== 1'b0) begin
         fails++;
         $display("FAIL mid_chk got=%b%b exp=10",
                  bus.busy, bus.btn_level);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({bus.t, bus.btn_level, bus.busy} !== 3'b000) begin
         fails++;
         $display("FAIL mid_reset got=%b exp=000",
                  {bus.t, bus.btn_level, bus.busy});
      end
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (bus.t === 1'b1) begin
            pulses++;
            at = i;
         end
      end
      checks++;
      if (pulses !== 1 || at !== N + 2) begin
         fails++;
         $display("FAIL mid_pulse got=%0d@%0d exp=1@%0d",
                  pulses, at, N + 2);
      end
   endtask

   task automatic test_random();
      int hold   = 0;
      int last   = -1;
      int pulses = 0;
      go_idle();
      bus.en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            bus.btn_in = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 3 * N));
         end
         hold--;
         if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
         reset = ($urandom_range(0, 299) == 0);
         tick();
         if (reset) last = -1;
         reset = 1'b0;
         checks++;
         if ({bus.t, bus.btn_level, bus.busy} !==
             {m_t, m_lvl, m_run != 0}) begin
            fails++;
            $display("FAIL rand_model cyc=%0d got=%b exp=%b", i,
                     {bus.t, bus.btn_level, bus.busy},
                     {m_t, m_lvl, m_run != 0});
         end
         if (bus.t === 1'b1) begin
            pulses++;
            checks++;
            if (last >= 0 && i - last < 2 * N) begin
               fails++;
               $display("FAIL rand_spacing cyc=%0d got=%0d min=%0d",
                        i, i - last, 2 * N);
            end
            last = i;
         end
      end
      checks++;
      if (pulses == 0) begin
         fails++;
         $display("FAIL rand_pulses got=0 exp=>0");
      end
   endtask

   initial begin
      bus.btn_in = 1'b1;
      bus.en     = 1'b1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_enable_gating();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
